// File: rtl/noc_pkg.sv
// noc_pkg: shared mesh-router packet layout, direction indices and packet type
package noc_pkg;
    localparam int WIDTH    = 35;
    localparam int SRC_X_HI = 34;
    localparam int SRC_X_LO = 33;
    localparam int SRC_Y_HI = 32;
    localparam int SRC_Y_LO = 31;
    localparam int DST_X_HI = 30;
    localparam int DST_X_LO = 29;
    localparam int DST_Y_HI = 28;
    localparam int DST_Y_LO = 27;
    localparam int DIR_N    = 0;
    localparam int DIR_W    = 1;
    localparam int DIR_S    = 2;
    localparam int DIR_PE   = 3;
    localparam int DIR_E    = 4;
    typedef logic [WIDTH-1:0] pkt_t;
endpackage

// File: rtl/router_out_arb_if.sv
// router_out_arb_if: input-side and link-side handshakes plus status of one output port
interface router_out_arb_if import noc_pkg::*; #(
    parameter int WIDTH  = noc_pkg::WIDTH,
    parameter int NUM_IN = 4
);
    localparam int GW = NUM_IN > 1 ? $clog2(NUM_IN) : 1;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic [15:0]             pkt_cnt;
    logic [GW-1:0]           last_grant;
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, pkt_cnt, last_grant
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, pkt_cnt, last_grant
    );
endinterface

// File: rtl/router_out_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant starting after ptr, ptr moves to the winner on accept
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = N > 1 ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] ptr;
    int j;
    // scan from farthest to nearest so the nearest requester after ptr wins
    always_comb begin
        gnt = '0;
        idx = ptr;
        j   = 0;
        for (int k = N; k >= 1; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
        if (!en) gnt = '0;
    end
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= IW'(N - 1);
        else if (|gnt)
            ptr <= idx;
    end
endmodule

// File: rtl/router_out_arb.sv
// router_out_arb: round-robin merge of routing stages into one output link through a small FIFO
module router_out_arb import noc_pkg::*; #(
    parameter int WIDTH  = noc_pkg::WIDTH,
    parameter int NUM_IN = 4,
    parameter int DEPTH  = 2
) (
    input logic clk,
    input logic rst,
    router_out_arb_if.slave bus
);
    localparam int GW = NUM_IN > 1 ? $clog2(NUM_IN) : 1;
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head, tail;
    logic [CW-1:0]    count;
    logic [NUM_IN-1:0] gnt;
    logic [GW-1:0]    idx, last_grant;
    logic [15:0]      pkt_cnt;
    logic             space, push, pop;
    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction
    // a pop on the same edge frees a slot, so a full FIFO can still accept
    assign space = !rst && (count < FULL || (bus.out_ready && count != '0));
    rr_arbiter #(.N(NUM_IN)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (bus.in_valid),
        .en  (space),
        .gnt (gnt),
        .idx (idx)
    );
    assign push           = |gnt;
    assign pop            = bus.out_valid && bus.out_ready;
    assign bus.in_ready   = gnt;
    assign bus.out_valid  = count != '0;
    assign bus.out_data   = mem[head];
    assign bus.pkt_cnt    = pkt_cnt;
    assign bus.last_grant = last_grant;
    always_ff @(posedge clk) begin
        if (push)
            mem[tail] <= bus.in_data[idx*WIDTH +: WIDTH];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            last_grant <= '0;
            pkt_cnt    <= '0;
        end else begin
            if (push) begin
                tail       <= inc(tail);
                last_grant <= idx;
                pkt_cnt    <= pkt_cnt + 16'd1;
            end
            if (pop)
                head <= inc(head);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_router_out_arb.sv
// tb_router_out_arb: scenario tasks with a packet scoreboard checked at the output link
module tb_router_out_arb;
    import noc_pkg::*;
    localparam int NI = 4;
    localparam int D  = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    pkt_t sb[$];
    always #5 clk = ~clk;
    router_out_arb_if #(.WIDTH(WIDTH), .NUM_IN(NI)) bus ();
    router_out_arb #(.WIDTH(WIDTH), .NUM_IN(NI), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    task automatic drv(input int i, input pkt_t v);
        bus.in_data[i*WIDTH +: WIDTH] = v;
    endtask
    task automatic nxt;
        @(posedge clk);
        #1;
    endtask
    task automatic pulse_reset;
        rst = 1'b1;
        bus.in_valid = '0;
        nxt;
        rst = 1'b0;
        sb.delete();
    endtask
    // every completed output handshake must deliver the oldest expected packet
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL out_unexpected got=%h exp=none", bus.out_data);
            end else begin
                pkt_t e;
                e = sb.pop_front();
                if (bus.out_data !== e) begin
                    failures++;
                    $display("FAIL out_data got=%h exp=%h", bus.out_data, e);
                end
            end
        end
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
    task automatic test_reset;
        rst = 1'b1;
        bus.in_valid = '1;
        bus.out_ready = 1'b1;
        bus.in_data = '0;
        nxt;
        nxt;
        @(negedge clk);
        checks++; if (bus.in_ready !== 4'b0000) begin failures++; $display("FAIL rst_in_ready got=%b exp=0000", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.pkt_cnt !== 16'h0) begin failures++; $display("FAIL rst_pkt_cnt got=%h exp=0000", bus.pkt_cnt); end
        checks++; if (bus.last_grant !== 2'd0) begin failures++; $display("FAIL rst_last_grant got=%0d exp=0", bus.last_grant); end
        nxt;
        rst = 1'b0;
        bus.in_valid = '0;
        sb.delete();
    endtask
    task automatic test_single;
        bus.out_ready = 1'b1;
        drv(2, 35'h1_2345_6789);
        bus.in_valid = 4'b0100;
        @(negedge clk);
        checks++; if (bus.in_ready !== 4'b0100) begin failures++; $display("FAIL single_in_ready got=%b exp=0100", bus.in_ready); end
        sb.push_back(35'h1_2345_6789);
        nxt;
        bus.in_valid = '0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_data !== 35'h1_2345_6789) begin failures++; $display("FAIL single_out_data got=%h exp=123456789", bus.out_data); end
        checks++; if (bus.pkt_cnt !== 16'd1) begin failures++; $display("FAIL single_pkt_cnt got=%0d exp=1", bus.pkt_cnt); end
        checks++; if (bus.last_grant !== 2'd2) begin failures++; $display("FAIL single_last_grant got=%0d exp=2", bus.last_grant); end
        nxt;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL single_drained got=%b exp=0", bus.out_valid); end
    endtask
    task automatic test_fairness;
        pkt_t v[NI];
        int n = 0;
        pulse_reset;
        bus.out_ready = 1'b1;
        for (int i = 0; i < NI; i++) begin
            v[i] = pkt_t'((i << 16) | n++);
            drv(i, v[i]);
        end
        bus.in_valid = '1;
        for (int c = 0; c < 8; c++) begin
            int e;
            logic [NI-1:0] oh;
            e = c % NI;
            oh = NI'(1 << e);
            @(negedge clk);
            checks++; if (bus.in_ready !== oh) begin failures++; $display("FAIL fair_grant%0d got=%b exp=%b", c, bus.in_ready, oh); end
            sb.push_back(v[e]);
            nxt;
            v[e] = pkt_t'((e << 16) | n++);
            drv(e, v[e]);
        end
        bus.in_valid = '0;
        @(negedge clk);
        checks++; if (bus.pkt_cnt !== 16'd8) begin failures++; $display("FAIL fair_pkt_cnt got=%0d exp=8", bus.pkt_cnt); end
        checks++; if (bus.last_grant !== 2'd3) begin failures++; $display("FAIL fair_last_grant got=%0d exp=3", bus.last_grant); end
        nxt;
        nxt;
    endtask
    task automatic test_backpressure;
        bus.out_ready = 1'b0;
        drv(0, 35'h0_AAAA_0001);
        drv(1, 35'h0_BBBB_0001);
        bus.in_valid = 4'b0011;
        @(negedge clk);
        checks++; if (bus.in_ready !== 4'b0001) begin failures++; $display("FAIL bp_first got=%b exp=0001", bus.in_ready); end
        sb.push_back(35'h0_AAAA_0001);
        nxt;
        bus.in_valid = 4'b0010;
        @(negedge clk);
        checks++; if (bus.in_ready !== 4'b0010) begin failures++; $display("FAIL bp_second got=%b exp=0010", bus.in_ready); end
        sb.push_back(35'h0_BBBB_0001);
        nxt;
        drv(1, 35'h0_BBBB_0002);
        @(negedge clk);
        checks++; if (bus.in_ready !== 4'b0000) begin failures++; $display("FAIL bp_full got=%b exp=0000", bus.in_ready); end
        checks++; if (bus.out_data !== 35'h0_AAAA_0001) begin failures++; $display("FAIL bp_head got=%h exp=0aaaa0001", bus.out_data); end
        nxt;
        @(negedge clk);
        checks++; if (bus.in_ready !== 4'b0000) begin failures++; $display("FAIL bp_full_hold got=%b exp=0000", bus.in_ready); end
        nxt;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 4'b0010) begin failures++; $display("FAIL bp_release got=%b exp=0010", bus.in_ready); end
        sb.push_back(35'h0_BBBB_0002);
        nxt;
        bus.in_valid = '0;
        repeat (3) nxt;
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL bp_lost got=%0d exp=0", sb.size()); end
    endtask
    task automatic test_full_pushpop;
        bus.out_ready = 1'b0;
        drv(3, 35'h3_0000_00A1);
        bus.in_valid = 4'b1000;
        @(negedge clk);
        checks++; if (bus.in_ready !== 4'b1000) begin failures++; $display("FAIL fp_fill1 got=%b exp=1000", bus.in_ready); end
        sb.push_back(35'h3_0000_00A1);
        nxt;
        drv(3, 35'h3_0000_00A2);
        @(negedge clk);
        checks++; if (bus.in_ready !== 4'b1000) begin failures++; $display("FAIL fp_fill2 got=%b exp=1000", bus.in_ready); end
        sb.push_back(35'h3_0000_00A2);
        nxt;
        drv(3, 35'h3_0000_00A3);
        @(negedge clk);
        checks++; if (bus.in_ready !== 4'b0000) begin failures++; $display("FAIL fp_full got=%b exp=0000", bus.in_ready); end
        nxt;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 4'b1000) begin failures++; $display("FAIL fp_pushpop got=%b exp=1000", bus.in_ready); end
        sb.push_back(35'h3_0000_00A3);
        nxt;
        bus.out_ready = 1'b0;
        drv(3, 35'h3_0000_00A4);
        @(negedge clk);
        checks++; if (bus.in_ready !== 4'b0000) begin failures++; $display("FAIL fp_still_full got=%b exp=0000", bus.in_ready); end
        checks++; if (bus.out_data !== 35'h3_0000_00A2) begin failures++; $display("FAIL fp_head got=%h exp=3000000a2", bus.out_data); end
        nxt;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 4'b1000) begin failures++; $display("FAIL fp_pushpop2 got=%b exp=1000", bus.in_ready); end
        sb.push_back(35'h3_0000_00A4);
        nxt;
        bus.in_valid = '0;
        repeat (3) nxt;
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL fp_lost got=%0d exp=0", sb.size()); end
    endtask
    task automatic test_reset_mid;
        bus.out_ready = 1'b0;
        drv(1, 35'h1_1111_0001);
        drv(2, 35'h2_2222_0002);
        bus.in_valid = 4'b0110;
        @(negedge clk);
        checks++; if (bus.in_ready !== 4'b0010) begin failures++; $display("FAIL rm_grant1 got=%b exp=0010", bus.in_ready); end
        nxt;
        bus.in_valid = 4'b0100;
        @(negedge clk);
        checks++; if (bus.in_ready !== 4'b0100) begin failures++; $display("FAIL rm_grant2 got=%b exp=0100", bus.in_ready); end
        nxt;
        rst = 1'b1;
        drv(0, 35'h0_F0F0_F0F0);
        bus.in_valid = 4'b1111;
        @(negedge clk);
        checks++; if (bus.in_ready !== 4'b0000) begin failures++; $display("FAIL rm_in_rst got=%b exp=0000", bus.in_ready); end
        nxt;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rm_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.pkt_cnt !== 16'h0) begin failures++; $display("FAIL rm_pkt_cnt got=%h exp=0000", bus.pkt_cnt); end
        checks++; if (bus.in_ready !== 4'b0001) begin failures++; $display("FAIL rm_first_grant got=%b exp=0001", bus.in_ready); end
        sb.push_back(35'h0_F0F0_F0F0);
        nxt;
        bus.in_valid = '0;
        @(negedge clk);
        checks++; if (bus.out_data !== 35'h0_F0F0_F0F0) begin failures++; $display("FAIL rm_new_head got=%h exp=0f0f0f0f0", bus.out_data); end
        nxt;
        bus.out_ready = 1'b1;
        nxt;
        nxt;
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL rm_lost got=%0d exp=0", sb.size()); end
    endtask
    task automatic test_wrap;
        pulse_reset;
        bus.out_ready = 1'b1;
        drv(0, 35'h5_5A5A_A5A5);
        bus.in_valid = 4'b0001;
        for (int i = 0; i < 65535; i++) begin
            @(negedge clk);
            sb.push_back(35'h5_5A5A_A5A5);
            nxt;
        end
        @(negedge clk);
        checks++; if (bus.pkt_cnt !== 16'hFFFF) begin failures++; $display("FAIL wrap_max got=%h exp=ffff", bus.pkt_cnt); end
        sb.push_back(35'h5_5A5A_A5A5);
        nxt;
        bus.in_valid = '0;
        @(negedge clk);
        checks++; if (bus.pkt_cnt !== 16'h0000) begin failures++; $display("FAIL wrap_zero got=%h exp=0000", bus.pkt_cnt); end
        nxt;
        nxt;
    endtask
    initial begin
        test_reset;
        test_single;
        test_fairness;
        test_backpressure;
        test_full_pushpop;
        test_reset_mid;
        test_wrap;
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL final_sb got=%0d exp=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/router_out_arb.md
# router_out_arb

Output-port stage of a mesh router: merges the packets produced by the per-direction routing stages that target one output port (e.g. the East output collects from the N, W, S and PE routing stages) onto a single outbound link. Round-robin arbitration among the inputs, a small output FIFO that decouples the arbiter from link backpressure, and a valid/ready handshake on every side. Packets pass through unmodified; coordinate rewriting has already been done by the upstream routing stage.

## Interface
- WIDTH, 35, packet width; header [34:33] src_x, [32:31] src_y, [30:29] dst_x, [28:27] dst_y, remainder payload
- NUM_IN, 4, number of contending input stages (index 0 = N, 1 = W, 2 = S, 3 = PE for the East port)
- DEPTH, 2, output FIFO entries (≥1)

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  NUM_IN  per-input packet valid
- in_data  in  NUM_IN*WIDTH  packed packets, input i at [i*WIDTH +: WIDTH]
- in_ready  out  NUM_IN  per-input accept, at most one bit high
- out_valid  out  1  FIFO head valid
- out_data  out  WIDTH  FIFO head packet
- out_ready  in  1  downstream accepts head
- pkt_cnt  out  16  packets accepted since reset, wraps
- last_grant  out  $clog2(NUM_IN)  index of most recently accepted input

## Operation
- space = (count < DEPTH) || (out_ready && count != 0).
- Grant: when space, grant the first i with in_valid[i], scanning from (ptr+1) mod NUM_IN upward with wrap; in_ready = one-hot grant, else all zero.
- in_ready is combinational from in_valid, count, out_ready, ptr; it never depends on itself. Upstream must hold in_valid and in_data stable until accepted.
- Accept at edge where in_valid[i] && in_ready[i]: push in_data[i] to FIFO tail, ptr ← i, last_grant ← i, pkt_cnt ← pkt_cnt+1 (0xFFFF → 0x0000).
- No accept: ptr, last_grant, pkt_cnt hold.
- Pop at edge where out_valid && out_ready: advance head.
- Simultaneous push and pop: count unchanged; legal when full (pushed entry lands in the freed slot); when count==1 the new packet becomes head on the next cycle.
- out_valid = (count != 0); out_data = head entry, registered storage, undefined content when out_valid=0.
- Payload and header bits passed unchanged; no field checking.
- Reset: count=0, head/tail=0, ptr=NUM_IN-1 (input 0 first priority), last_grant=0, pkt_cnt=0, out_valid=0, in_ready=0 for every cycle rst is high. Reset mid-operation discards FIFO contents and any in-flight handshake; no packet may appear on out after rst deasserts until newly accepted.

## Timing
- Latency: packet accepted at edge k is on out_data with out_valid=1 in the cycle after edge k (1 cycle) when FIFO was empty.
- Throughput: one packet per cycle sustained when out_ready stays high.
- Fairness: with all inputs continuously valid and no backpressure, grants cycle 0,1,2,3,0,… ; any requesting input waits at most NUM_IN-1 accepts.
- Backpressure: out_ready low with count==DEPTH forces in_ready=0 in that cycle.

## Structure
- Shared package noc_pkg: WIDTH default, header field bit positions (SRC_X_HI/LO … DST_Y_HI/LO), direction index constants (DIR_N, DIR_W, DIR_S, DIR_PE, DIR_E), packet typedef.
- Sub-module rr_arbiter: combinational round-robin grant from request vector and ptr, plus registered ptr update on accept. FIFO stays inline (circular buffer, head/tail/count).

## Test plan
- Single packet: after reset, in_valid[2]=1 with 0x1_2345_6789 → in_ready=4'b0100 same cycle, out_valid=1 with out_data=0x1_2345_6789 next cycle, pkt_cnt=1, last_grant=2.
- Fairness: all four inputs valid, out_ready=1 for 8 cycles → grant order 0,1,2,3,0,1,2,3, pkt_cnt=8.
- Backpressure: out_ready=0, inputs 0 and 1 valid → two accepts (0 then 1), then in_ready=0 while full; raise out_ready → head=input0 packet, then input1, no loss or duplication.
- Full with simultaneous push/pop: count=DEPTH, out_ready=1, input 3 valid → accept and pop same edge, count stays DEPTH, order preserved.
- Reset mid-stream: FIFO holding 2 packets, assert rst one cycle → out_valid=0, pkt_cnt=0, next grant goes to input 0 when all valid.
- Counter wrap: preload via 65536 accepts → pkt_cnt returns to 0x0000.
